// File: rtl/aesl_axis_stall_detector.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : aesl_axis_stall_detector
// Purpose  : Per-channel AXI-Stream stall detector for the co-simulation
//            deadlock-monitor tree. Each channel runs a small FSM
//            (IDLE/COUNT/BLOCKED) that declares the channel blocked once a
//            stall persists for STALL_THRESH consecutive cycles. A sticky
//            report captures the first channel to block.
// Ports    : clock           - rising-edge clock
//            reset           - asynchronous, active-low reset
//            ch_tvalid/tready- per-channel handshake observed on the DUT
//            inst_idle       - DUT ap_idle; forces every channel to IDLE
//            clr_first       - synchronous clear of the sticky report
//            axis_block_sigs - registered per-channel blocked flags
//            any_block       - registered OR of axis_block_sigs
//            first_block_vld - sticky: some channel has entered BLOCKED
//            first_block_ch  - lowest index that entered on that edge
//            stall_events    - saturating count of BLOCKED entries
//                              (only with AESL_STALL_STATS_EN)
// Options  : AESL_STALL_STATS_EN - adds the stall_events counter/port
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module aesl_axis_stall_detector #(
  parameter int                NUM_CH       = 2,
  parameter int                STALL_THRESH = 16,
  parameter int                CNT_W        = 16,
  parameter logic [NUM_CH-1:0] CH_IS_INPUT  = 2'b01
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [NUM_CH-1:0]                         ch_tvalid,
  input  logic [NUM_CH-1:0]                         ch_tready,
  input  logic                                      inst_idle,
  input  logic                                      clr_first,
  output logic [NUM_CH-1:0]                         axis_block_sigs,
  output logic                                      any_block,
  output logic                                      first_block_vld,
`ifdef AESL_STALL_STATS_EN
  output logic [15:0]                               stall_events,
`endif
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_block_ch
);

  localparam int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] c_thresh = CNT_W'(STALL_THRESH);
  localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COUNT   = 2'd1,
    S_BLOCKED = 2'd2
  } state_t;

  logic [NUM_CH-1:0] w_enter;     // channel transitions into BLOCKED this edge
  logic [NUM_CH-1:0] w_blk_next;  // channel will be BLOCKED after this edge
  logic [CH_W-1:0]   w_low_idx;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_t           r_state;
      logic [CNT_W-1:0] r_cnt;
      logic             r_blk;
      logic             w_stall;
      logic             w_hit;
      logic [CNT_W-1:0] w_cnt_inc;

      // Consumer side is starved when ready waits on valid; producer side is
      // back-pressured when valid waits on ready.
      assign w_stall   = CH_IS_INPUT[g] ? (ch_tready[g] & ~ch_tvalid[g])
                                        : (ch_tvalid[g] & ~ch_tready[g]);
      assign w_cnt_inc = r_cnt + c_one;

      // Threshold reached by the stall sampled on this edge. From IDLE the
      // count would become 1, so only a threshold of 1 hits there.
      always_comb begin
        w_hit = 1'b0;
        case (r_state)
          S_IDLE:  w_hit = (c_thresh == c_one);
          S_COUNT: w_hit = (w_cnt_inc == c_thresh);
          default: w_hit = 1'b0;
        endcase
      end

      assign w_enter[g]    = ~inst_idle & w_stall & w_hit;
      assign w_blk_next[g] = ~inst_idle & w_stall & (w_hit | (r_state == S_BLOCKED));

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_blk   <= 1'b0;
        end else if (inst_idle || !w_stall) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_blk   <= 1'b0;
        end else begin
          case (r_state)
            S_IDLE, S_COUNT: begin
              if (w_hit) begin
                r_state <= S_BLOCKED;
                r_cnt   <= c_thresh;
                r_blk   <= 1'b1;
              end else begin
                r_state <= S_COUNT;
                r_cnt   <= (r_state == S_IDLE) ? c_one : w_cnt_inc;
                r_blk   <= 1'b0;
              end
            end
            S_BLOCKED: begin
              // Counter parks at the threshold; it never wraps.
              r_state <= S_BLOCKED;
              r_cnt   <= c_thresh;
              r_blk   <= 1'b1;
            end
            default: begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_blk   <= 1'b0;
            end
          endcase
        end
      end

      assign axis_block_sigs[g] = r_blk;
    end
  endgenerate

  // Lowest entering index: scan high to low so the lowest match is last.
  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_enter[i]) w_low_idx = CH_W'(i);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      any_block <= 1'b0;
    end else begin
      any_block <= |w_blk_next;
    end
  end

  // A new entry on the clearing edge re-arms the report rather than losing it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      first_block_vld <= 1'b0;
      first_block_ch  <= '0;
    end else if ((|w_enter) && (!first_block_vld || clr_first)) begin
      first_block_vld <= 1'b1;
      first_block_ch  <= w_low_idx;
    end else if (clr_first) begin
      first_block_vld <= 1'b0;
      first_block_ch  <= '0;
    end
  end

`ifdef AESL_STALL_STATS_EN
  logic [16:0] w_nent;
  logic [16:0] w_sum;

  always_comb begin
    w_nent = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_nent = w_nent + {16'd0, w_enter[i]};
    end
  end

  assign w_sum = {1'b0, stall_events} + w_nent;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_events <= '0;
    end else if (clr_first) begin
      stall_events <= w_nent[16] ? 16'hFFFF : w_nent[15:0];
    end else begin
      stall_events <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_aesl_axis_stall_detector.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_aesl_axis_stall_detector
// Purpose  : Self-checking bench for aesl_axis_stall_detector. Three instances
//            (threshold 4, threshold 1, and CNT_W=4/threshold 15) share one
//            stimulus stream. A run-length model predicts every output each
//            cycle; directed literal checks pin the model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_aesl_axis_stall_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] tv, tr;
  logic       idle, clr;

  logic [1:0] blk  [3];
  logic       anyb [3];
  logic       fv   [3];
  logic       fc   [3];
`ifdef AESL_STALL_STATS_EN
  logic [15:0] ev  [3];
`endif

  always #5 clk = ~clk;

  aesl_axis_stall_detector #(.NUM_CH(2), .STALL_THRESH(4), .CNT_W(16), .CH_IS_INPUT(2'b01)) u_a (
    .clock(clk), .reset(rst_n), .ch_tvalid(tv), .ch_tready(tr), .inst_idle(idle),
    .clr_first(clr), .axis_block_sigs(blk[0]), .any_block(anyb[0]),
    .first_block_vld(fv[0]),
`ifdef AESL_STALL_STATS_EN
    .stall_events(ev[0]),
`endif
    .first_block_ch(fc[0]));

  aesl_axis_stall_detector #(.NUM_CH(2), .STALL_THRESH(1), .CNT_W(16), .CH_IS_INPUT(2'b01)) u_b (
    .clock(clk), .reset(rst_n), .ch_tvalid(tv), .ch_tready(tr), .inst_idle(idle),
    .clr_first(clr), .axis_block_sigs(blk[1]), .any_block(anyb[1]),
    .first_block_vld(fv[1]),
`ifdef AESL_STALL_STATS_EN
    .stall_events(ev[1]),
`endif
    .first_block_ch(fc[1]));

  aesl_axis_stall_detector #(.NUM_CH(2), .STALL_THRESH(15), .CNT_W(4), .CH_IS_INPUT(2'b01)) u_c (
    .clock(clk), .reset(rst_n), .ch_tvalid(tv), .ch_tready(tr), .inst_idle(idle),
    .clr_first(clr), .axis_block_sigs(blk[2]), .any_block(anyb[2]),
    .first_block_vld(fv[2]),
`ifdef AESL_STALL_STATS_EN
    .stall_events(ev[2]),
`endif
    .first_block_ch(fc[2]));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int th(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  // Model: a channel is blocked exactly when its current run of consecutive
  // stall samples has reached the threshold.
  int run  [3][2];
  bit mb   [3][2];
  bit mvld [3];
  int mch  [3];
  int mev  [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int c = 0; c < 2; c++) begin
          run[i][c] = 0;
          mb[i][c]  = 1'b0;
        end
        mvld[i] = 1'b0;
        mch[i]  = 0;
        mev[i]  = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int nent;
        int low;
        bit st;
        bit nb;
        nent = 0;
        low  = -1;
        for (int c = 0; c < 2; c++) begin
          // channel 0 is consumed by the DUT, channel 1 is produced by it
          st = (c == 0) ? (tr[0] & ~tv[0]) : (tv[1] & ~tr[1]);
          if (idle || !st) run[i][c] = 0;
          else if (run[i][c] < 1000000) run[i][c]++;
          nb = (run[i][c] >= th(i));
          if (nb && !mb[i][c]) begin
            nent++;
            if (low < 0) low = c;
          end
          mb[i][c] = nb;
        end
        if (nent > 0 && (!mvld[i] || clr)) begin
          mvld[i] = 1'b1;
          mch[i]  = low;
        end else if (clr) begin
          mvld[i] = 1'b0;
          mch[i]  = 0;
        end
        if (clr) mev[i] = nent;
        else     mev[i] = (mev[i] + nent > 65535) ? 65535 : mev[i] + nent;
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_blk[%0d]", i), int'(blk[i]), int'({mb[i][1], mb[i][0]}));
        chk($sformatf("model_any[%0d]", i), int'(anyb[i]), int'(mb[i][1] | mb[i][0]));
        chk($sformatf("model_vld[%0d]", i), int'(fv[i]), int'(mvld[i]));
        chk($sformatf("model_ch[%0d]", i), int'(fc[i]), mch[i]);
`ifdef AESL_STALL_STATS_EN
        chk($sformatf("model_ev[%0d]", i), int'(ev[i]), mev[i]);
`endif
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; tv = 2'b00; tr = 2'b00; idle = 1'b0; clr = 1'b0;
    #2;
    chk("reset_blk", int'(blk[0]), 0);
    chk("reset_any", int'(anyb[0]), 0);
    chk("reset_vld", int'(fv[0]), 0);
    chk("reset_ch",  int'(fc[0]), 0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // channel 0 starved from here on
    tr = 2'b01; tv = 2'b00;
    cyc(1); chk("t1_b_thresh1", int'(blk[1]), 1);
    cyc(2); chk("t1_a_3edges", int'(blk[0]), 0);
    cyc(1); chk("t1_a_4edges", int'(blk[0]), 1);
    chk("t1_a_vld", int'(fv[0]), 1);
    chk("t1_a_ch",  int'(fc[0]), 0);
    tv = 2'b01;
    cyc(1); chk("t1_a_deassert", int'(blk[0]), 0);

    // channel 1 back-pressured, broken by one handshake
    tv = 2'b10; tr = 2'b00;
    cyc(3); chk("t2_pre_hs", int'(blk[0][1]), 0);
    tr = 2'b10;
    cyc(1); chk("t2_hs", int'(blk[0][1]), 0);
    tr = 2'b00;
    cyc(3); chk("t2_post_hs", int'(blk[0][1]), 0);
    tv = 2'b00;
    cyc(1);

    // clear with nothing entering
    clr = 1'b1;
    cyc(1); clr = 1'b0;
    chk("clr_vld", int'(fv[0]), 0);

    // both channels stall from the same edge
    tr = 2'b01; tv = 2'b10;
    cyc(3); chk("both_early", int'(blk[0]), 0);
    cyc(1); chk("both_blk", int'(blk[0]), 3);
    chk("both_ch",  int'(fc[0]), 0);
    chk("both_any", int'(anyb[0]), 1);
`ifdef AESL_STALL_STATS_EN
    chk("both_ev", int'(ev[0]), 2);
`endif

    // inst_idle pulse while blocked
    idle = 1'b1;
    cyc(1); idle = 1'b0;
    chk("idle_drop", int'(blk[0]), 0);
    cyc(3); chk("idle_3", int'(blk[0]), 0);
    cyc(1); chk("idle_4", int'(blk[0]), 3);

    // long stall: narrow counter must park at its threshold
    cyc(40);
    chk("hold_c", int'(blk[2]), 3);
    chk("hold_a", int'(blk[0]), 3);

    // asynchronous reset between edges while blocked
    #3 rst_n = 1'b0;
    #1;
    chk("areset_blk", int'(blk[0]), 0);
    chk("areset_any", int'(anyb[0]), 0);
    chk("areset_vld", int'(fv[0]), 0);
    chk("areset_c",   int'(blk[2]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(3); chk("rel_3", int'(blk[0]), 0);
    cyc(1); chk("rel_4", int'(blk[0]), 3);

    // threshold 1: a single stall cycle blocks, one clean cycle releases
    tr = 2'b00; tv = 2'b00;
    cyc(2);
    tr = 2'b01;
    cyc(1); chk("t1only_set", int'(blk[1]), 1);
    tr = 2'b00;
    cyc(1); chk("t1only_clr", int'(blk[1]), 0);

    // clear coinciding with a new entry: the new entry is reported
    tv = 2'b10; clr = 1'b1;
    cyc(1); clr = 1'b0;
    chk("clrset_vld", int'(fv[1]), 1);
    chk("clrset_ch",  int'(fc[1]), 1);

    tv = 2'b00;
    cyc(2);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aesl_axis_stall_detector.md
# aesl_axis_stall_detector

Per-channel AXI-Stream stall detector for the yolo_yolo co-simulation deadlock-monitor tree. It watches TVALID/TREADY of every DUT stream port and declares a channel "blocked" once a stall persists for a programmable number of cycles. It produces the `axis_block_sigs` vector consumed directly by the top-level deadlock monitor. An optional sticky report captures the first channel to block.

## Interface
Parameters:
- `NUM_CH`, 2: number of monitored stream channels; index matches `axis_block_sigs` bit order.
- `STALL_THRESH`, 16: consecutive stall cycles before a channel is declared blocked; legal range 1..2^CNT_W-1.
- `CNT_W`, 16: stall-counter width.
- `CH_IS_INPUT`, 2'b01: per-channel direction; bit=1 means the DUT consumes the stream, bit=0 means the DUT produces it.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ch_tvalid` in NUM_CH: TVALID per channel.
- `ch_tready` in NUM_CH: TREADY per channel.
- `inst_idle` in 1: DUT ap_idle; high forces every channel to IDLE.
- `axis_block_sigs` out NUM_CH: registered per-channel blocked flag.
- `any_block` out 1: registered OR of `axis_block_sigs`.
- `first_block_vld` out 1: sticky; set when any channel first enters BLOCKED.
- `first_block_ch` out $clog2(NUM_CH) (min 1): index of that channel; lowest index wins ties.
- `clr_first` in 1: synchronous clear of the sticky report.

## Operation
- Stall condition per channel c:
  - Input channel: `ch_tready & ~ch_tvalid`. The DUT is starved.
  - Output channel: `ch_tvalid & ~ch_tready`. The DUT is back-pressured.
- Per-channel FSM, three states:
  - IDLE, cnt=0:
    - stall → COUNT with cnt=1.
    - If STALL_THRESH==1, go directly to BLOCKED.
  - COUNT:
    - stall and cnt+1==STALL_THRESH → BLOCKED.
    - stall otherwise → cnt+1.
    - no stall → IDLE with cnt=0.
  - BLOCKED:
    - counter holds at STALL_THRESH and never wraps.
    - no stall → IDLE.
    - `axis_block_sigs[c]` is 1 only in this state.
- Handshake (`tvalid&tready`) and quiescence (both low) are both treated as no stall.
- `inst_idle`=1 has priority over everything else: all FSMs go to IDLE with cnt=0 on that edge.
- Sticky report:
  - On the first edge where any FSM enters BLOCKED while `first_block_vld`=0: set `first_block_vld` and latch the lowest entering index.
  - Later entries do not overwrite the report.
  - `clr_first`=1 clears `first_block_vld` and `first_block_ch`. If a channel enters BLOCKED on the same edge, the set wins.
- Arithmetic: the counter is unsigned CNT_W bits and compares with equality against STALL_THRESH. It is never incremented past STALL_THRESH.

## Timing
- Reset (reset=0, asynchronous):
  - all FSMs IDLE, cnt=0.
  - `axis_block_sigs`=0, `any_block`=0, `first_block_vld`=0, `first_block_ch`=0.
- Assertion latency: with the stall first sampled at edge k, `axis_block_sigs[c]` is high after edge k+STALL_THRESH-1. It is visible STALL_THRESH cycles after the stall began.
- Deassertion: one cycle. The output falls after the first edge that samples no stall.
- `any_block` and `first_block_vld` update on the same edge as `axis_block_sigs`; there is no extra pipeline stage.
- Reset asserted mid-count or mid-BLOCKED clears immediately, with no waiting for an edge. Counting restarts from zero after release.
- A single non-stall cycle inside a stall run restarts the count from zero.

## Configuration
- `AESL_STALL_STATS_EN` defined:
  - adds output `stall_events` (16 bits).
  - it increments on every IDLE/COUNT→BLOCKED transition, summed over channels; simultaneous entries add the count of entering channels.
  - it saturates at 16'hFFFF and is cleared by reset and by `clr_first`.
- Macro not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- THRESH=4, channel 0 input:
  - Stimulus: tready=1, tvalid=0 from cycle 0.
  - Required: `axis_block_sigs`=2'b01 and `first_block_ch`=0 after 4 edges.
  - Then tvalid=1: the bit falls after 1 edge.
- THRESH=4, channel 1 output:
  - Stimulus: tvalid=1, tready=0 for 3 cycles, 1 handshake cycle, then 3 more stall cycles.
  - Required: `axis_block_sigs[1]` never asserts.
- Both channels start stalling on the same edge:
  - Required: `axis_block_sigs`=2'b11 on the same edge, `first_block_ch`=0, and `stall_events`=2 with the macro.
- `inst_idle` pulsed for 1 cycle while channel 0 is BLOCKED:
  - Required: the output drops the next edge and reasserts only after 4 more stall edges.
- Async reset asserted mid-edge-window while BLOCKED:
  - Required: all outputs 0 immediately.
  - `clr_first` with no new block: `first_block_vld`=0 the next cycle.
- THRESH=1, channel 0 input, one stall cycle:
  - Required: blocked after 1 edge.
- CNT_W=4, THRESH=15, stall held for 40 cycles:
  - Required: counter holds at 15 and the output stays 1.
